and_16_core: RTL and testbench
==============================

// Module: and_16_core
//
// PURPOSE
//   16-bit bitwise AND gate element for the gate library.
//   - Combinational path: out = a & b, zero latency; the primary function.
//   - Optional registered copy of the result, with a valid strobe and status flags
//     (zero, popcount), for pipelined datapaths such as the ALU stage.
//
// PARAMETERS
//   WIDTH    16   operand/result width in bits; all checks below assume 16
//   CNT_W    5    popcount width, = clog2(WIDTH+1)
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   a          in   16     operand A
//   b          in   16     operand B
//   in_valid   in   1      capture strobe for the registered path
//   out        out  16     combinational result a & b
//   out_q      out  16     registered result
//   out_valid  out  1      out_q/zero_q/pop_q were updated on the last edge
//   zero_q     out  1      1 when out_q == 0
//   pop_q      out  5      number of 1 bits in out_q (0..16)
//
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//   - out[i] = a[i] & b[i] for every i.
//     - Purely combinational; independent of clk, rst_n and in_valid.
//     - Settles within the same delta as input changes.
//   - Reset (rst_n = 0, asserted asynchronously):
//     - out_q = 16'h0000, out_valid = 0, zero_q = 1, pop_q = 0.
//     - Release is synchronised to the next rising clk edge; the first capture is
//       possible on that edge.
//   - Rising clk edge, rst_n = 1, in_valid = 1:
//     - out_q  <= a & b
//     - zero_q <= ((a & b) == 0)
//     - pop_q  <= popcount(a & b)
//     - out_valid <= 1
//   - Rising clk edge, rst_n = 1, in_valid = 0:
//     - out_q, zero_q and pop_q hold their values.
//     - out_valid <= 0.
//   - Latency: 1 cycle, a/b/in_valid -> out_q/out_valid.
//   - Throughput: 1 result per cycle; no backpressure, no ready signal.
//   - zero_q and pop_q are always consistent with out_q; never combinational from a/b.
//   - Reset asserted mid-stream:
//     - Registered outputs go to reset values immediately.
//     - out is unaffected.
//   - No X propagation from the registers: every flop has a reset value.
//
// TESTING
//   - Comb: a=16'h0000, b=16'hFFFF -> out=16'h0000 after #10.
//   - Comb: a=16'hAAAA, b=16'h5555 -> out=16'h0000.
//   - Comb: a=16'h1234, b=16'h9876 -> out=16'h1034.
//   - Reg: rst_n released; a=16'h1234, b=16'h9876, in_valid=1, one edge
//     -> out_q=16'h1034, zero_q=0, pop_q=4, out_valid=1.
//       Next edge with in_valid=0 -> out_q held, out_valid=0.
//   - Reg: a=b=16'hFFFF, in_valid=1 -> out_q=16'hFFFF, pop_q=16, zero_q=0.
//     Then a=16'hAAAA, b=16'h5555 -> out_q=0, zero_q=1, pop_q=0.
//   - Reset mid-op: drop rst_n between edges while out_q=16'hFFFF
//     -> out_q=0, out_valid=0, zero_q=1 with no clock edge; out still tracks a & b.

Source files
------------

// File: rtl/and_16_core.sv
// 16-bit bitwise AND element with an optional registered result.
// The registered path also carries a valid strobe and zero/popcount flags.
module and_16_core #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic [CNT_W-1:0] pop_q
);

  logic [WIDTH-1:0] w_and;
  logic [CNT_W-1:0] w_pop;
  logic             w_zero;

  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_zero;
  logic [CNT_W-1:0] r_pop;

  assign w_and  = a & b;
  assign w_zero = (w_and == '0);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CNT_W'(w_and[i]);
    end
  end

  // Flags are computed from the same operands as the captured result,
  // so they can never disagree with out_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_zero  <= 1'b1;
      r_pop   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out  <= w_and;
        r_zero <= w_zero;
        r_pop  <= w_pop;
      end
    end
  end

  assign out       = w_and;
  assign out_q     = r_out;
  assign out_valid = r_valid;
  assign zero_q    = r_zero;
  assign pop_q     = r_pop;

endmodule

// File: tb/tb_and_16_core.sv
// Directed self-checking bench for and_16_core.
// Inputs change on the falling edge; registered outputs are sampled 1ns after the rising edge.
module tb_and_16_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_valid;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        out_valid;
  logic        zero_q;
  logic [4:0]  pop_q;

  int vectors;
  int miscompares;

  and_16_core #(.WIDTH(16), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .out      (out),
    .out_q    (out_q),
    .out_valid(out_valid),
    .zero_q   (zero_q),
    .pop_q    (pop_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic rise_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 16'h1234;
    b = 16'h9876;
    in_valid = 1'b1;
    rise_sample();
    rise_sample();
    vectors++;
    if (out_q !== 16'h0000) begin
      $display("FAIL reset_out_q got=%h exp=%h", out_q, 16'h0000);
      miscompares++;
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      miscompares++;
    end
    vectors++;
    if (zero_q !== 1'b1) begin
      $display("FAIL reset_zero_q got=%b exp=1", zero_q);
      miscompares++;
    end
    vectors++;
    if (pop_q !== 5'd0) begin
      $display("FAIL reset_pop_q got=%0d exp=0", pop_q);
      miscompares++;
    end
  endtask

  task automatic test_comb();
    a = 16'h0000;
    b = 16'hFFFF;
    #10;
    vectors++;
    if (out !== 16'h0000) begin
      $display("FAIL comb_zero got=%h exp=%h", out, 16'h0000);
      miscompares++;
    end
    a = 16'hAAAA;
    b = 16'h5555;
    #1;
    vectors++;
    if (out !== 16'h0000) begin
      $display("FAIL comb_alt got=%h exp=%h", out, 16'h0000);
      miscompares++;
    end
    a = 16'h1234;
    b = 16'h9876;
    #1;
    vectors++;
    if (out !== 16'h1034) begin
      $display("FAIL comb_mixed got=%h exp=%h", out, 16'h1034);
      miscompares++;
    end
    a = 16'hFFFF;
    b = 16'hFFFF;
    #1;
    vectors++;
    if (out !== 16'hFFFF) begin
      $display("FAIL comb_ones got=%h exp=%h", out, 16'hFFFF);
      miscompares++;
    end
  endtask

  task automatic test_capture_hold();
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'h1234;
    b = 16'h9876;
    in_valid = 1'b1;
    rise_sample();
    vectors++;
    if (out_q !== 16'h1034 || zero_q !== 1'b0 ||
        pop_q !== 5'd4 || out_valid !== 1'b1) begin
      $display("FAIL capture got=%h/%b/%0d/%b exp=1034/0/4/1",
               out_q, zero_q, pop_q, out_valid);
      miscompares++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hFFFF;
    b = 16'hFFFF;
    rise_sample();
    vectors++;
    if (out_q !== 16'h1034 || zero_q !== 1'b0 ||
        pop_q !== 5'd4 || out_valid !== 1'b0) begin
      $display("FAIL hold got=%h/%b/%0d/%b exp=1034/0/4/0",
               out_q, zero_q, pop_q, out_valid);
      miscompares++;
    end
  endtask

  task automatic test_ones_then_zero();
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    in_valid = 1'b1;
    rise_sample();
    vectors++;
    if (out_q !== 16'hFFFF || zero_q !== 1'b0 ||
        pop_q !== 5'd16 || out_valid !== 1'b1) begin
      $display("FAIL all_ones got=%h/%b/%0d/%b exp=ffff/0/16/1",
               out_q, zero_q, pop_q, out_valid);
      miscompares++;
    end
    @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    rise_sample();
    vectors++;
    if (out_q !== 16'h0000 || zero_q !== 1'b1 ||
        pop_q !== 5'd0 || out_valid !== 1'b1) begin
      $display("FAIL alt_zero got=%h/%b/%0d/%b exp=0000/1/0/1",
               out_q, zero_q, pop_q, out_valid);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] vq [3];
    logic [4:0]  vp [3];
    va = '{16'hF0F0, 16'h0001, 16'h8000};
    vb = '{16'hFF00, 16'h0001, 16'hFFFF};
    vq = '{16'hF000, 16'h0001, 16'h8000};
    vp = '{5'd4, 5'd1, 5'd1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      in_valid = 1'b1;
      rise_sample();
      vectors++;
      if (out_q !== vq[i] || pop_q !== vp[i] ||
          zero_q !== 1'b0 || out_valid !== 1'b1) begin
        $display("FAIL b2b[%0d] got=%h/%0d/%b/%b exp=%h/%0d/0/1",
                 i, out_q, pop_q, zero_q, out_valid, vq[i], vp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    in_valid = 1'b1;
    rise_sample();
    vectors++;
    if (out_q !== 16'hFFFF) begin
      $display("FAIL mid_pre got=%h exp=ffff", out_q);
      miscompares++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_q !== 16'h0000 || out_valid !== 1'b0 ||
        zero_q !== 1'b1 || pop_q !== 5'd0) begin
      $display("FAIL mid_reset got=%h/%b/%b/%0d exp=0000/0/1/0",
               out_q, out_valid, zero_q, pop_q);
      miscompares++;
    end
    vectors++;
    if (out !== 16'hFFFF) begin
      $display("FAIL mid_comb got=%h exp=ffff", out);
      miscompares++;
    end
    a = 16'h1234;
    b = 16'h9876;
    #1;
    vectors++;
    if (out !== 16'h1034) begin
      $display("FAIL mid_track got=%h exp=1034", out);
      miscompares++;
    end
    rise_sample();
    vectors++;
    if (out_q !== 16'h0000 || out_valid !== 1'b0) begin
      $display("FAIL mid_held got=%h/%b exp=0000/0", out_q, out_valid);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    rise_sample();
    vectors++;
    if (out_q !== 16'h1034 || pop_q !== 5'd4 || out_valid !== 1'b1) begin
      $display("FAIL mid_release got=%h/%0d/%b exp=1034/4/1",
               out_q, pop_q, out_valid);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_comb();
    test_capture_hold();
    test_ones_then_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
